// File: rtl/alu_mc.sv
// rtl/alu_mc.sv - multi-cycle ALU with iterative multiply/shift and registered NZCV flags
//
// Ports:
//   clk, reset        rising-edge clock, asynchronous active-high reset
//   start             request, accepted only while the FSM is idle
//   control[3:0]      opcode, captured with the accepted start
//   S                 flag-update enable, captured with the accepted start
//   DATA_A, DATA_B    operands; DATA_B[SW-1:0] is the shift amount
//   OUT               registered result, changes only when done pulses
//   done              one-cycle completion pulse
//   busy              iterative operation still in progress
//   N, Z, CO, OVF     registered flag file
module alu_mc #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       control,
  input  logic             S,
  input  logic [WIDTH-1:0] DATA_A,
  input  logic [WIDTH-1:0] DATA_B,
  output logic [WIDTH-1:0] OUT,
  output logic             done,
  output logic             busy,
  output logic             N,
  output logic             Z,
  output logic             CO,
  output logic             OVF
);

  localparam int SW = $clog2(WIDTH);

  localparam logic [3:0] OP_AND = 4'b0000, OP_EOR = 4'b0001, OP_SUB = 4'b0010, OP_RSB = 4'b0011;
  localparam logic [3:0] OP_ADD = 4'b0100, OP_ADC = 4'b0101, OP_SBC = 4'b0110, OP_RSC = 4'b0111;
  localparam logic [3:0] OP_MUL = 4'b1000, OP_LSL = 4'b1001, OP_LSR = 4'b1010, OP_ASR = 4'b1011;
  localparam logic [3:0] OP_ORR = 4'b1100, OP_MOV = 4'b1101, OP_BIC = 4'b1110, OP_MVN = 4'b1111;

  typedef enum logic {IDLE, EXEC} state_t;

  state_t state, state_next;

  logic [3:0]       ctl_r;
  logic             s_r;
  logic [WIDTH-1:0] a_r, b_r;
  logic [WIDTH-1:0] acc, mcand, mplier, sh;
  logic [SW:0]      cnt, lat, lat_in;
  logic [SW-1:0]    k_in, k_r;

  logic             accept, last;
  logic [WIDTH-1:0] x, y, res, mul_sum, sh_next;
  logic [WIDTH:0]   sum;
  logic             ci, sh_out, co_new, ovf_new, co_upd, ovf_upd;

  assign accept = (state == IDLE) && start;
  assign k_in   = DATA_B[SW-1:0];
  assign k_r    = b_r[SW-1:0];
  // cnt counts EXEC edges already taken; the edge where it reaches lat-1 finishes
  assign last   = (cnt == lat - (SW+1)'(1));

  always_comb begin
    lat_in = (SW+1)'(1);
    if (control == OP_MUL)
      lat_in = (SW+1)'(WIDTH);
    else if ((control == OP_LSL || control == OP_LSR || control == OP_ASR) && k_in != '0)
      lat_in = {1'b0, k_in};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = EXEC;
      EXEC:    if (last)  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // One adder serves all arithmetic ops; subtraction is A + ~B + carry-in
  always_comb begin
    x  = a_r;
    y  = b_r;
    ci = 1'b0;
    case (ctl_r)
      OP_SUB:  begin y = ~b_r; ci = 1'b1; end
      OP_RSB:  begin x = b_r; y = ~a_r; ci = 1'b1; end
      OP_ADC:  ci = CO;
      OP_SBC:  begin y = ~b_r; ci = CO; end
      OP_RSC:  begin x = b_r; y = ~a_r; ci = CO; end
      default: ;
    endcase
    sum = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, ci};
  end

  assign mul_sum = acc + (mplier[0] ? mcand : '0);

  always_comb begin
    sh_next = sh;
    sh_out  = 1'b0;
    case (ctl_r)
      OP_LSL:  begin sh_next = {sh[WIDTH-2:0], 1'b0};       sh_out = sh[WIDTH-1]; end
      OP_LSR:  begin sh_next = {1'b0, sh[WIDTH-1:1]};       sh_out = sh[0]; end
      OP_ASR:  begin sh_next = {sh[WIDTH-1], sh[WIDTH-1:1]}; sh_out = sh[0]; end
      default: ;
    endcase
  end

  always_comb begin
    res     = '0;
    co_new  = 1'b0;
    ovf_new = 1'b0;
    co_upd  = 1'b0;
    ovf_upd = 1'b0;
    case (ctl_r)
      OP_AND, OP_EOR, OP_ORR, OP_MOV, OP_BIC, OP_MVN: begin
        co_upd  = 1'b1;
        ovf_upd = 1'b1;
        case (ctl_r)
          OP_AND:  res = a_r & b_r;
          OP_EOR:  res = a_r ^ b_r;
          OP_ORR:  res = a_r | b_r;
          OP_MOV:  res = b_r;
          OP_BIC:  res = a_r & ~b_r;
          default: res = ~b_r;
        endcase
      end
      OP_SUB, OP_RSB, OP_ADD, OP_ADC, OP_SBC, OP_RSC: begin
        res     = sum[WIDTH-1:0];
        co_new  = sum[WIDTH];
        ovf_new = (x[WIDTH-1] == y[WIDTH-1]) && (sum[WIDTH-1] != x[WIDTH-1]);
        co_upd  = 1'b1;
        ovf_upd = 1'b1;
      end
      OP_MUL: res = mul_sum;
      default: begin
        // zero-length shift passes A through and leaves the carry alone
        if (k_r == '0) begin
          res = a_r;
        end else begin
          res    = sh_next;
          co_new = sh_out;
          co_upd = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctl_r  <= '0;
      s_r    <= 1'b0;
      a_r    <= '0;
      b_r    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      sh     <= '0;
      cnt    <= '0;
      lat    <= '0;
      OUT    <= '0;
      done   <= 1'b0;
      busy   <= 1'b0;
      N      <= 1'b0;
      Z      <= 1'b0;
      CO     <= 1'b0;
      OVF    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        ctl_r  <= control;
        s_r    <= S;
        a_r    <= DATA_A;
        b_r    <= DATA_B;
        acc    <= '0;
        mcand  <= DATA_A;
        mplier <= DATA_B;
        sh     <= DATA_A;
        cnt    <= '0;
        lat    <= lat_in;
        busy   <= 1'b0;
      end else if (state == EXEC) begin
        if (last) begin
          OUT  <= res;
          done <= 1'b1;
          busy <= 1'b0;
          if (s_r) begin
            N <= res[WIDTH-1];
            Z <= (res == '0);
            if (co_upd)  CO  <= co_new;
            if (ovf_upd) OVF <= ovf_new;
          end
        end else begin
          cnt    <= cnt + (SW+1)'(1);
          busy   <= 1'b1;
          acc    <= mul_sum;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          sh     <= sh_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// tb/tb_alu_mc.sv - directed and randomized self-checking bench for alu_mc
module tb_alu_mc;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset, start, S;
  logic [3:0]   control;
  logic [W-1:0] DATA_A, DATA_B, OUT;
  logic         done, busy, N, Z, CO, OVF;

  int checks = 0;
  int errors = 0;

  logic         m_n, m_z, m_c, m_v;
  logic [W-1:0] m_out;
  int           m_lat;

  always #5 clk = ~clk;

  alu_mc #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .control(control), .S(S),
    .DATA_A(DATA_A), .DATA_B(DATA_B), .OUT(OUT), .done(done), .busy(busy),
    .N(N), .Z(Z), .CO(CO), .OVF(OVF)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic from the opcode table
  task automatic model(input logic [3:0] op, input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
    int ua, ub, sa, sb, k, c, r, sr;
    logic co, ov, cu, vu;
    ua = a; ub = b; sa = $signed(a); sb = $signed(b);
    k = ub % W; c = m_c;
    r = 0; sr = 0; co = 1'b0; ov = 1'b0; cu = 1'b0; vu = 1'b0;
    m_lat = 1;
    case (op)
      4'd0:  begin r = ua & ub;  cu = 1; vu = 1; end
      4'd1:  begin r = ua ^ ub;  cu = 1; vu = 1; end
      4'd12: begin r = ua | ub;  cu = 1; vu = 1; end
      4'd13: begin r = ub;       cu = 1; vu = 1; end
      4'd14: begin r = ua & ~ub; cu = 1; vu = 1; end
      4'd15: begin r = ~ub;      cu = 1; vu = 1; end
      4'd2:  begin r = ua - ub; co = (ua >= ub); sr = sa - sb; end
      4'd3:  begin r = ub - ua; co = (ub >= ua); sr = sb - sa; end
      4'd4:  begin r = ua + ub; co = (r >= (1 << W)); sr = sa + sb; end
      4'd5:  begin r = ua + ub + c; co = (r >= (1 << W)); sr = sa + sb + c; end
      4'd6:  begin r = ua - ub - 1 + c; co = (r >= 0); sr = sa - sb - 1 + c; end
      4'd7:  begin r = ub - ua - 1 + c; co = (r >= 0); sr = sb - sa - 1 + c; end
      4'd8:  begin r = ua * ub; m_lat = W; end
      default: begin
        if (op == 4'd9)       r = ua << k;
        else if (op == 4'd10) r = ua >> k;
        else                  r = sa >>> k;
        if (k > 0) begin
          m_lat = k;
          cu = 1;
          co = (op == 4'd9) ? (((ua >> (W - k)) & 1) != 0) : (((ua >> (k - 1)) & 1) != 0);
        end
      end
    endcase
    if (op inside {[4'd2:4'd7]}) begin
      cu = 1; vu = 1;
      ov = (sr > (2 ** (W - 1)) - 1) || (sr < -(2 ** (W - 1)));
    end
    m_out = r[W-1:0];
    if (s) begin
      m_n = m_out[W-1];
      m_z = (m_out == 0);
      if (cu) m_c = co;
      if (vu) m_v = ov;
    end
  endtask

  // Entered and left at 1 time unit after a rising edge, so ops chain back-to-back
  task automatic run_op(input logic [3:0] op, input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
    control = op; S = s; DATA_A = a; DATA_B = b; start = 1'b1;
    model(op, s, a, b);
    @(posedge clk); #1;
    start = 1'b0;
    control = 4'($urandom); S = 1'($urandom); DATA_A = W'($urandom); DATA_B = W'($urandom);
    check("t0_done", done, 0);
    check("t0_busy", busy, 0);
    for (int c = 1; c <= m_lat; c++) begin
      @(posedge clk); #1;
      if (c < m_lat) begin
        check("mid_busy", busy, 1);
        check("mid_done", done, 0);
      end else begin
        check("done", done, 1);
        check("end_busy", busy, 0);
        check("out", OUT, m_out);
        check("n", N, m_n);
        check("z", Z, m_z);
        check("co", CO, m_c);
        check("ovf", OVF, m_v);
      end
      // a start pulse while busy must not disturb the running op
      if (c == 2 && m_lat > 3) start = 1'b1;
      if (c == 3) start = 1'b0;
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; control = '0; S = 1'b0; DATA_A = '0; DATA_B = '0;
    m_n = 0; m_z = 0; m_c = 0; m_v = 0; m_out = '0;
    #12;
    check("rst_out", OUT, 0);
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
    check("rst_flags", {N, Z, CO, OVF}, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    run_op(4'd4, 1, 8'h7F, 8'h01);
    run_op(4'd2, 1, 8'h05, 8'h05);
    run_op(4'd5, 1, 8'h10, 8'h20);
    run_op(4'd8, 1, 8'h0F, 8'h11);
    run_op(4'd11, 1, 8'h81, 8'h03);
    run_op(4'd9, 1, 8'h81, 8'h01);
    run_op(4'd10, 1, 8'h5A, 8'h08);
    run_op(4'd4, 1, 8'hFF, 8'h81);
    run_op(4'd12, 0, 8'h00, 8'h00);

    for (int i = 0; i < 60; i++) begin
      run_op(4'($urandom), 1'($urandom), W'($urandom), W'($urandom));
      if ($urandom_range(3) == 0) begin
        repeat ($urandom_range(3, 1)) begin @(posedge clk); #1; end
      end
    end

    run_op(4'd4, 1, 8'hFF, 8'h81);
    control = 4'd8; S = 1'b1; DATA_A = 8'h33; DATA_B = 8'h55; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check("abort_out", OUT, 0);
    check("abort_done", done, 0);
    check("abort_busy", busy, 0);
    check("abort_flags", {N, Z, CO, OVF}, 0);
    m_n = 0; m_z = 0; m_c = 0; m_v = 0;
    @(posedge clk); #1;
    reset = 1'b0;
    run_op(4'd4, 1, 8'h01, 8'h01);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
